slave: RTL
==========

# slave

Responder end of the A/D request–response channel pair driven by `master`. It accepts one request at a time on channel A: full write, partial (byte-masked) write, or read. It services the request against an internal 16-word × 32-bit register memory and returns exactly one response on channel D after a programmable wait. It is the single target instance on the bus in the lab top level.

## Interface
- `LATENCY`, default 1: wait cycles inserted between request acceptance and assertion of `d_valid`. Range 0–15.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset. Asynchronous and active-low.
- `a_valid` in 1: request valid.
- `a_opcode` in 4: request opcode. 0 = PutFullData, 1 = PutPartialData, 4 = Get.
- `a_mask` in 4: byte enables. Bit i covers `a_data[8i+7:8i]`.
- `a_address` in 4: word address, 0–15.
- `a_data` in 32: write data.
- `a_ready` out 1: slave can accept a request.
- `d_ready` in 1: master can accept a response.
- `d_valid` out 1: response valid.
- `d_opcode` out 4: response opcode. 0 = AccessAck, 1 = AccessAckData.
- `d_data` out 32: read data; 0 for AccessAck.
- `d_error` out 1: request had an unsupported opcode.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- `a_ready` = (state == IDLE). It is combinational from the state register.
- **Reset values:** `a_ready`=1, `d_valid`=0, `d_opcode`=0, `d_data`=0, `d_error`=0, and all 16 memory words = 0.
- **IDLE:**
  - A request is accepted on the edge where `a_valid & a_ready`.
  - The accepted opcode, mask and address are latched.
  - If `LATENCY` = 0, next state is RESP; otherwise next state is WAIT with the counter loaded to `LATENCY`-1.
- **WAIT:** the counter decrements each cycle. When the counter is 0, next state is RESP.
- **RESP:**
  - `d_valid`=1, and `d_opcode`/`d_data`/`d_error` are stable.
  - On the edge where `d_valid & d_ready`, next state is IDLE and `d_valid`, `d_opcode`, `d_data` and `d_error` clear to 0.
- **Opcode behaviour:**
  - PutFullData writes all 4 bytes, ignoring `a_mask`.
  - PutPartialData writes only the bytes whose mask bit is 1. A mask of 0 writes nothing but still gets an AccessAck.
  - Get produces AccessAckData. `d_data` is the addressed word with bytes whose mask bit is 0 forced to 0x00.
  - Any other opcode: no memory change. Response is AccessAck with `d_data`=0 and `d_error`=1.
- Memory writes take effect on the acceptance edge.
- Get data is captured from memory on the acceptance edge, so a later write cannot alter a pending response. With one outstanding request this cannot happen in practice.
- Only one transaction is outstanding at a time. A request presented while not in IDLE is not accepted and must be held by the master.
- `d_ready` held permanently high is legal. The response then completes in its first RESP cycle.
- **Reset mid-operation** returns the FSM to IDLE, drops the response, and clears the memory.

## Timing
- Acceptance edge is E0.
- `d_valid` rises after edge E0+`LATENCY`.
  - With `LATENCY`=0, `d_valid` is high in the cycle after E0.
  - With `LATENCY`=1, `d_valid` is high 2 cycles after `a_valid` was sampled.
- Minimum request-to-request spacing is `LATENCY`+2 cycles when `d_ready`=1.
- `a_ready` returns to 1 in the cycle after the D handshake edge.
  - A new request may be accepted on the following edge.
  - There is no same-edge D completion and A acceptance.
- All outputs are glitch-free registers or decodes of the state register. There is no combinational path from any A/D input to any output.

## Structure
- **Shared package `tl_pkg`:**
  - Opcode constants: PUT_FULL=4'h0, PUT_PART=4'h1, GET=4'h4, ACK=4'h0, ACK_DATA=4'h1.
  - State encoding for IDLE/WAIT/RESP.
  - Address and data width constants (4, 32).
- **Sub-module `slave_mem`:**
  - 16×32 register array with asynchronous active-low clear.
  - Per-byte write enables.
  - Combinational read port.
- The `slave` top contains the FSM, the wait counter, the request latches and the response registers.

## Test plan
- **Full write then read:**
  - Stimulus: PutFullData addr 3, data 0xDEADBEEF, mask 0xF. Then Get addr 3, mask 0xF.
  - Response: AccessAck with `d_error`=0. Then AccessAckData with `d_data`=0xDEADBEEF.
- **Partial write:**
  - Stimulus: PutFullData addr 5 = 0x11223344. Then PutPartialData addr 5, data 0xAABBCCDD, mask 0x5. Then Get addr 5, mask 0xF.
  - Response: `d_data`=0x11BB33DD.
- **Masked read:** Get addr 5 (after the previous scenario) with mask 0x3 returns `d_data`=0x000033DD.
- **Latency and backpressure:**
  - Stimulus: `LATENCY`=3. Hold `d_ready`=0 for 4 cycles after `d_valid` rises.
  - Response: `d_valid` rises exactly 3 edges after acceptance and stays high with stable `d_data` until `d_ready`=1. `a_ready` stays 0 throughout.
- **Illegal opcode and held request:**
  - Stimulus: opcode 4'h7 to addr 2. Then hold a second request during RESP.
  - Response: AccessAck with `d_error`=1 and memory word 2 unchanged. The second request is accepted only on the edge after the D handshake.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 during WAIT after a write to addr 1.
  - Response: `d_valid`=0 and `a_ready`=1 immediately. A subsequent Get addr 1 returns 0x00000000.

Source files
------------

// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the A/D request-response channel pair: opcode
// constants, widths, the responder FSM state encoding, the response record
// and a helper that forms a response from a request and the addressed word.
// ---------------------------------------------------------------------------
package tl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    // Channel A opcodes
    localparam logic [3:0] PUT_FULL = 4'h0;
    localparam logic [3:0] PUT_PART = 4'h1;
    localparam logic [3:0] GET      = 4'h4;

    // Channel D opcodes
    localparam logic [3:0] ACK      = 4'h0;
    localparam logic [3:0] ACK_DATA = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [DATA_W-1:0] data;
        logic              error;
    } rsp_t;

    // Forms the D-channel response for a request. For Get, bytes whose mask
    // bit is clear read back as 0x00. Unknown opcodes are acknowledged with
    // the error flag set and no data.
    function automatic rsp_t build_rsp(input logic [3:0]        opcode,
                                       input logic [MASK_W-1:0] mask,
                                       input logic [DATA_W-1:0] word);
        rsp_t r;
        r = '0;
        case (opcode)
            GET: begin
                r.opcode = ACK_DATA;
                for (int i = 0; i < MASK_W; i++) begin
                    r.data[8*i +: 8] = mask[i] ? word[8*i +: 8] : 8'h00;
                end
            end
            PUT_FULL, PUT_PART: r.opcode = ACK;
            default: begin
                r.opcode = ACK;
                r.error  = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/slave_mem.sv
// ---------------------------------------------------------------------------
// slave_mem
// 16 x 32 register memory with per-byte write enables, a combinational read
// port and asynchronous active-low clear of every word.
//   clk, rst_n : clock, asynchronous active-low clear
//   we         : per-byte write enables for word waddr
//   waddr/wdata: write address and data
//   raddr/rdata: combinational read port
// ---------------------------------------------------------------------------
module slave_mem
    import tl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MASK_W-1:0] we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < MASK_W; b++) begin
            if (we[b]) begin
                mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // NOTE: this array is deliberately reset; the bus contract requires every
    // word to read as zero after reset, so it cannot map onto a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/slave.sv
// ---------------------------------------------------------------------------
// slave
// Responder on the A/D channel pair. Accepts one request at a time on A
// (PutFullData, PutPartialData, Get), services it against a 16-word memory
// and returns a single response on D after LATENCY wait cycles.
//   LATENCY             : wait cycles between acceptance and d_valid (0-15)
//   clk, rst_n          : clock, asynchronous active-low reset
//   a_valid/a_ready     : request handshake
//   a_opcode/a_mask/
//   a_address/a_data    : request fields
//   d_valid/d_ready     : response handshake
//   d_opcode/d_data/
//   d_error             : response fields (all registered)
// ---------------------------------------------------------------------------
module slave
    import tl_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [3:0]        a_opcode,
    input  logic [MASK_W-1:0] a_mask,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              d_ready,
    output logic              d_valid,
    output logic [3:0]        d_opcode,
    output logic [DATA_W-1:0] d_data,
    output logic              d_error
);

    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        req_opcode_q, req_opcode_d;
    logic [MASK_W-1:0] req_mask_q, req_mask_d;
    logic [DATA_W-1:0] req_word_q, req_word_d;   // addressed word captured at acceptance
    rsp_t              rsp_q, rsp_d;

    logic [MASK_W-1:0] mem_we;
    logic [DATA_W-1:0] mem_rdata;

    slave_mem u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (a_address),
        .wdata (a_data),
        .raddr (a_address),
        .rdata (mem_rdata)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_opcode_d = req_opcode_q;
        req_mask_d   = req_mask_q;
        req_word_d   = req_word_q;
        rsp_d        = rsp_q;
        mem_we       = '0;

        case (state_q)
            ST_IDLE: begin
                if (a_valid) begin
                    req_opcode_d = a_opcode;
                    req_mask_d   = a_mask;
                    req_word_d   = mem_rdata;
                    if (a_opcode == PUT_FULL) begin
                        mem_we = '1;
                    end else if (a_opcode == PUT_PART) begin
                        mem_we = a_mask;
                    end
                    if (LATENCY == 0) begin
                        // No wait stage: the latches are not yet loaded, so
                        // the response is formed straight from the request.
                        state_d = ST_RESP;
                        rsp_d   = build_rsp(a_opcode, a_mask, mem_rdata);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    rsp_d   = build_rsp(req_opcode_q, req_mask_q, req_word_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (d_ready) begin
                    state_d = ST_IDLE;
                    rsp_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rsp_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_opcode_q <= '0;
            req_mask_q   <= '0;
            req_word_q   <= '0;
            rsp_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_opcode_q <= req_opcode_d;
            req_mask_q   <= req_mask_d;
            req_word_q   <= req_word_d;
            rsp_q        <= rsp_d;
        end
    end

    assign a_ready  = (state_q == ST_IDLE);
    assign d_valid  = (state_q == ST_RESP);
    assign d_opcode = rsp_q.opcode;
    assign d_data   = rsp_q.data;
    assign d_error  = rsp_q.error;

endmodule
